// File: rtl/mul_div_if.sv
// Handshake and operand/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div_zero, overflow
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div_zero, overflow
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO results.
// Operands are latched as unsigned magnitudes; signs are restored in a single fixup cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    mul_div_if.slave bus_io
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               sp_dz_q, sp_dz_d;
    logic               sp_ovf_q, sp_ovf_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic               in_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum, shifted, trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        in_signed = ~bus_io.op[0];
        abs_a     = (in_signed && bus_io.a[WIDTH-1]) ? -bus_io.a : bus_io.a;
        abs_b     = (in_signed && bus_io.b[WIDTH-1]) ? -bus_io.b : bus_io.b;
        // WIDTH+1 bit add keeps the carry that is shifted into the product.
        sum       = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
        shifted   = {acc_q, mq_q[WIDTH-1]};
        trial     = shifted - {1'b0, opb_q};
        prod      = {acc_q, mq_q};
        if (neg_res_q) begin
            prod = -prod;
        end
        quo = neg_res_q ? -mq_q : mq_q;
        rem = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opb_d      = opb_q;
        a_d        = a_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        sp_dz_d    = sp_dz_q;
        sp_ovf_d   = sp_ovf_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start && !bus_io.flush) begin
                    op_d      = bus_io.op;
                    a_d       = bus_io.a;
                    acc_d     = '0;
                    mq_d      = bus_io.op[1] ? abs_a : abs_b;
                    opb_d     = bus_io.op[1] ? abs_b : abs_a;
                    neg_res_d = in_signed & (bus_io.a[WIDTH-1] ^ bus_io.b[WIDTH-1]);
                    neg_rem_d = in_signed & bus_io.a[WIDTH-1];
                    sp_dz_d   = bus_io.op[1] && (bus_io.b == '0);
                    sp_ovf_d  = (bus_io.op == 2'b10) && (bus_io.a == {1'b1, {(WIDTH-1){1'b0}}})
                                && (bus_io.b == '1);
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (bus_io.flush) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[1]) begin
                        acc_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
                    end else begin
                        acc_d = sum[WIDTH:1];
                        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StFixup;
                    end
                end
            end
            StFixup: begin
                state_d = StIdle;
                if (!bus_io.flush) begin
                    done_d     = 1'b1;
                    div_zero_d = sp_dz_q;
                    overflow_d = sp_ovf_q & ~sp_dz_q;
                    if (sp_dz_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else if (sp_ovf_q) begin
                        lo_d = a_q;
                        hi_d = '0;
                    end else if (op_q[1]) begin
                        lo_d = quo;
                        hi_d = rem;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            opb_q      <= '0;
            a_q        <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            sp_dz_q    <= 1'b0;
            sp_ovf_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opb_q      <= opb_d;
            a_q        <= a_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            sp_dz_q    <= sp_dz_d;
            sp_ovf_q   <= sp_ovf_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.done     = done_q;
    assign bus_io.hi       = hi_q;
    assign bus_io.lo       = lo_q;
    assign bus_io.div_zero = div_zero_q;
    assign bus_io.overflow = overflow_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus hand sequences, scoreboard on done.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(32)) m32 ();
    mul_div_if #(.WIDTH(8))  m8 ();

    mul_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus_io(m32));
    mul_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus_io(m8));

    typedef struct packed {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        logic        ovf;
        int          issue;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        ovf;
    } vec_t;

    exp_t q32[$];
    exp_t q8[$];
    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   dones32 = 0;
    int   dones8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    always @(negedge clk) begin
        if (m32.done === 1'b1) begin
            exp_t e;
            dones32++;
            if (q32.size() == 0) begin
                flag_fail("unexpected_done32");
            end else begin
                e = q32.pop_front();
                check("hi32", 64'(m32.hi), e.hi);
                check("lo32", 64'(m32.lo), e.lo);
                check("dz32", 64'(m32.div_zero), 64'(e.dz));
                check("ovf32", 64'(m32.overflow), 64'(e.ovf));
                check("latency32", 64'(cyc - e.issue), 64'd34);
            end
        end
        if (m8.done === 1'b1) begin
            exp_t e;
            dones8++;
            if (q8.size() == 0) begin
                flag_fail("unexpected_done8");
            end else begin
                e = q8.pop_front();
                check("hi8", 64'(m8.hi), e.hi);
                check("lo8", 64'(m8.lo), e.lo);
                check("dz8", 64'(m8.div_zero), 64'(e.dz));
                check("ovf8", 64'(m8.overflow), 64'(e.ovf));
                check("latency8", 64'(cyc - e.issue), 64'd10);
            end
        end
    end

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz, input logic eovf, input bit b2b);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (m32.busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) flag_fail("issue32_timeout");
        if (b2b) check("b2b_done_cycle", 64'(m32.done), 64'd1);
        m32.op = op;
        m32.a = a;
        m32.b = b;
        m32.start = 1'b1;
        if (push) begin
            e.hi = 64'(ehi);
            e.lo = 64'(elo);
            e.dz = edz;
            e.ovf = eovf;
            e.issue = cyc;
            q32.push_back(e);
        end
        @(negedge clk);
        m32.start = 1'b0;
        check("busy_after_start32", 64'(m32.busy), 64'd1);
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (m8.busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) flag_fail("issue8_timeout");
        m8.op = op;
        m8.a = a;
        m8.b = b;
        m8.start = 1'b1;
        e.hi = 64'(ehi);
        e.lo = 64'(elo);
        e.dz = 1'b0;
        e.ovf = 1'b0;
        e.issue = cyc;
        q8.push_back(e);
        @(negedge clk);
        m8.start = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q32.size() != 0 || q8.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) flag_fail("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        int d0;
        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0};

        m32.start = 1'b0; m32.op = '0; m32.a = '0; m32.b = '0; m32.flush = 1'b0;
        m8.start = 1'b0;  m8.op = '0;  m8.a = '0;  m8.b = '0;  m8.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(m32.busy), 64'd0);
        check("rst_done", 64'(m32.done), 64'd0);
        check("rst_hi", 64'(m32.hi), 64'd0);
        check("rst_lo", 64'(m32.lo), 64'd0);
        check("rst_flags", 64'({m32.div_zero, m32.overflow}), 64'd0);
        rst_n = 1'b1;

        // Each row after the first is issued in the previous row's done cycle.
        for (int i = 0; i < 12; i++) begin
            issue32(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo,
                    vecs[i].dz, vecs[i].ovf, i > 0);
        end
        drain();

        // Start pulses while busy must be ignored.
        d0 = dones32;
        issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            m32.op = 2'b01; m32.a = 32'd5; m32.b = 32'd5; m32.start = 1'b1;
            @(negedge clk);
            m32.start = 1'b0;
        end
        drain();
        repeat (40) @(negedge clk);
        check("single_done_when_busy_start", 64'(dones32 - d0), 64'd1);

        // Flush mid-CALC: results from the previous op must survive.
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001,
                1'b0, 1'b0, 1'b0);
        drain();
        d0 = dones32;
        issue32(2'b00, 32'd5, 32'd5, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        m32.flush = 1'b1;
        @(negedge clk);
        m32.flush = 1'b0;
        check("flush_busy", 64'(m32.busy), 64'd0);
        check("flush_done", 64'(m32.done), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(dones32 - d0), 64'd0);
        check("flush_hi_hold", 64'(m32.hi), 64'hFFFFFFFE);
        check("flush_lo_hold", 64'(m32.lo), 64'h00000001);

        // Flush and start together in IDLE: start is dropped.
        m32.op = 2'b01; m32.a = 32'd2; m32.b = 32'd2; m32.start = 1'b1; m32.flush = 1'b1;
        @(negedge clk);
        m32.start = 1'b0; m32.flush = 1'b0;
        check("flush_start_idle_busy", 64'(m32.busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_start_no_done", 64'(dones32 - d0), 64'd0);

        // Asynchronous reset mid-CALC.
        issue32(2'b00, 32'd9, 32'd9, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(m32.busy), 64'd0);
        check("arst_hi", 64'(m32.hi), 64'd0);
        check("arst_lo", 64'(m32.lo), 64'd0);
        check("arst_done_flags", 64'({m32.done, m32.div_zero, m32.overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Narrow instance.
        issue8(2'b10, 8'h81, 8'h04, 8'hFD, 8'hE1);
        issue8(2'b00, 8'h81, 8'h04, 8'hFE, 8'h04);
        issue8(2'b11, 8'hFF, 8'h10, 8'h0F, 8'h0F);
        drain();
        check("q32_empty", 64'(q32.size()), 64'd0);
        check("q8_empty", 64'(q8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
